// File: rtl/mips32_pkg.sv
// Shared types for the MIPS32 pipeline hazard controller.
// In-flight slot record, forwarding-select encodings, zero register.
package mips32_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] wr_reg;
        logic       is_load;
    } slot_t;

    localparam logic [1:0] FWD_REG   = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A slot only tracks a real register write; R0 writes are dropped.
    function automatic slot_t mk_slot(input logic       wr_en,
                                      input logic [4:0] wr_reg,
                                      input logic       is_load);
        slot_t s;
        s.valid   = wr_en && (wr_reg != REG_ZERO);
        s.wr_reg  = wr_reg;
        s.is_load = is_load;
        return s;
    endfunction

endpackage

// File: rtl/mips32_hzd_cmp.sv
// Compares one source register against the EX and MEM slots.
// Ports: src/uses in, ex_slot/mem_slot in, hazard/sel out. Macro: MIPS32_FWD_EN.
module mips32_hzd_cmp
    import mips32_pkg::*;
(
    input  logic [4:0] src,
    input  logic       uses,
    input  slot_t      ex_slot,
    input  slot_t      mem_slot,
    output logic       hazard,
    output logic [1:0] sel
);

    logic live;
    logic hit_ex;
    logic hit_mem;

    assign live    = uses && (src != REG_ZERO);
    assign hit_ex  = live && ex_slot.valid && (ex_slot.wr_reg == src);
    assign hit_mem = live && mem_slot.valid && (mem_slot.wr_reg == src);

`ifdef MIPS32_FWD_EN
    // MEM holds load data by the time it reaches MEM/WB, so only
    // the load type of the EX slot matters.
    logic unused_bits;
    assign unused_bits = mem_slot.is_load;

    // EX is the younger producer and wins over MEM.
    always_comb begin
        hazard = 1'b0;
        sel    = FWD_REG;
        if (hit_ex) begin
            if (ex_slot.is_load) begin
                hazard = 1'b1;
            end else begin
                sel = FWD_EXMEM;
            end
        end else if (hit_mem) begin
            sel = FWD_MEMWB;
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ex_slot.is_load ^ mem_slot.is_load;

    assign hazard = hit_ex || hit_mem;
    assign sel    = FWD_REG;
`endif

endmodule

// File: rtl/mips32_hazard_ctrl.sv
// MIPS32 issue/stall/halt controller with optional forwarding (MIPS32_FWD_EN).
// Ports: clk1, rst, id_* decode info, ex_flush; issue, stall, halted, busy, fwd_a_sel, fwd_b_sel.
module mips32_hazard_ctrl
    import mips32_pkg::*;
(
    input  logic       clk1,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rs,
    input  logic       id_uses_rt,
    input  logic       id_wr_en,
    input  logic [4:0] id_wr_reg,
    input  logic       id_is_load,
    input  logic       id_is_halt,
    input  logic       ex_flush,
    output logic       issue,
    output logic       stall,
    output logic       halted,
    output logic       busy,
    output logic [1:0] fwd_a_sel,
    output logic [1:0] fwd_b_sel
);

    slot_t ex_q;
    slot_t mem_q;
    logic  halt_pending_q;
    logic  halted_q;
    logic  hz_a;
    logic  hz_b;
    logic  hazard;

    mips32_hzd_cmp u_cmp_rs (
        .src      (id_rs),
        .uses     (id_uses_rs),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .hazard   (hz_a),
        .sel      (fwd_a_sel)
    );

    mips32_hzd_cmp u_cmp_rt (
        .src      (id_rt),
        .uses     (id_uses_rt),
        .ex_slot  (ex_q),
        .mem_slot (mem_q),
        .hazard   (hz_b),
        .sel      (fwd_b_sel)
    );

    assign hazard = hz_a | hz_b;
    assign issue  = ~rst & id_valid & ~hazard & ~ex_flush & ~halt_pending_q;
    assign stall  = ~rst & id_valid & ~issue & ~ex_flush;
    assign busy   = ex_q.valid | mem_q.valid;
    assign halted = halted_q;

    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ex_q           <= '0;
            mem_q          <= '0;
            halt_pending_q <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            mem_q <= ex_q;
            ex_q  <= issue ? mk_slot(id_wr_en, id_wr_reg, id_is_load) : '0;
            halt_pending_q <= halt_pending_q | (issue & id_is_halt);
            // Registered: rises the cycle after the drained state is seen.
            halted_q <= halted_q | (halt_pending_q & ~busy);
        end
    end

endmodule
